// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: Moore FSM driving the register/synchronizer strobes.
// Define ROUTER_FSM_ADDR_CHK_EN to drop packets addressed to the nonexistent port 3.
module router_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
`ifdef ROUTER_FSM_ADDR_CHK_EN
        , DROP_PACKET
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       empty_sel, soft_sel, hdr_empty;

    // Port 3 does not exist, so it never reports empty or soft reset.
    function automatic logic pick3(input logic [1:0] sel, input logic v0, input logic v1,
                                   input logic v2);
        logic r;
        case (sel)
            2'd0:    r = v0;
            2'd1:    r = v1;
            2'd2:    r = v2;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        empty_sel = pick3(addr_q, fifo_empty_0, fifo_empty_1, fifo_empty_2);
        soft_sel  = pick3(addr_q, soft_reset_0, soft_reset_1, soft_reset_2);
        hdr_empty = pick3(data_in, fifo_empty_0, fifo_empty_1, fifo_empty_2);
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q == DECODE_ADDRESS && pkt_valid) begin
            addr_d = data_in;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // NOTE: next state defaults to the current state before the case, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (soft_sel) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
`ifdef ROUTER_FSM_ADDR_CHK_EN
                    else if (pkt_valid) begin
                        state_d = DROP_PACKET;
                    end
`endif
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)       state_d = FIFO_FULL_STATE;
                    else if (!pkt_valid) state_d = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) state_d = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)        state_d = DECODE_ADDRESS;
                    else if (low_pkt_valid) state_d = LOAD_PARITY;
                    else                    state_d = LOAD_DATA;
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (empty_sel) state_d = LOAD_FIRST_DATA;
                end
`ifdef ROUTER_FSM_ADDR_CHK_EN
                DROP_PACKET: begin
                    if (!pkt_valid) state_d = DECODE_ADDRESS;
                end
`endif
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state_q)
            DECODE_ADDRESS:  detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm; state is observed through the 8 decoded outputs.
// Define ROUTER_FSM_ADDR_CHK_EN here too to exercise the drop-packet path.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [7:0] obs;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt, ri_cnt;

    // Output vector order: detect_add, lfd, ld, laf, full, write_enb, rst_int, busy.
    localparam logic [7:0] S_DEC  = 8'b1000_0000;
    localparam logic [7:0] S_LFD  = 8'b0100_0001;
    localparam logic [7:0] S_LD   = 8'b0010_0100;
    localparam logic [7:0] S_LAF  = 8'b0001_0101;
    localparam logic [7:0] S_FFS  = 8'b0000_1001;
    localparam logic [7:0] S_LP   = 8'b0000_0101;
    localparam logic [7:0] S_CPE  = 8'b0000_0011;
    localparam logic [7:0] S_WTE  = 8'b0000_0001;
    localparam logic [7:0] S_DROP = 8'b0000_0000;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                  write_enb_reg, rst_int_reg, busy};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        #3 check("reset_hold", obs, S_DEC);
        step(); step();
        rst = 1'b0;
        step();
        check("after_reset", obs, S_DEC);

        // Normal packet to port 1: header, 4 payload cycles, parity.
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        step(); check("p1_lfd", obs, S_LFD);
        we_cnt = int'(write_enb_reg); ri_cnt = int'(rst_int_reg);
        data_in = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step(); check($sformatf("p1_ld%0d", i), obs, S_LD);
            we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
        end
        pkt_valid = 1'b0;
        step(); check("p1_lp", obs, S_LP);
        we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
        step(); check("p1_cpe", obs, S_CPE);
        we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
        step(); check("p1_dec", obs, S_DEC);
        we_cnt += int'(write_enb_reg); ri_cnt += int'(rst_int_reg);
        check("p1_we_cycles", 8'(we_cnt), 8'd5);
        check("p1_rstint_cycles", 8'(ri_cnt), 8'd1);

        // Port 2 busy for 5 cycles, then full stalls inside the payload.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); check($sformatf("p2_wte%0d", i), obs, S_WTE);
        end
        fifo_empty_2 = 1'b1;
        step(); check("p2_lfd", obs, S_LFD);
        step(); check("p2_ld", obs, S_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check($sformatf("p2_ffs%0d", i), obs, S_FFS);
        end
        fifo_full = 1'b0;
        step(); check("p2_laf", obs, S_LAF);
        step(); check("p2_laf_to_ld", obs, S_LD);
        fifo_full = 1'b1;
        step(); check("p2_ffs_again", obs, S_FFS);
        fifo_full = 1'b0;
        step(); check("p2_laf_again", obs, S_LAF);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step(); check("p2_laf_to_lp", obs, S_LP);
        low_pkt_valid = 1'b0;
        step(); check("p2_cpe", obs, S_CPE);
        fifo_full = 1'b1;
        step(); check("p2_cpe_full", obs, S_FFS);
        fifo_full = 1'b0;
        step(); check("p2_laf_final", obs, S_LAF);
        parity_done = 1'b1;
        step(); check("p2_parity_done", obs, S_DEC);
        parity_done = 1'b0;

        // Port 0: full beats end-of-packet; parity_done beats low_pkt_valid.
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        step(); check("p0_lfd", obs, S_LFD);
        step(); check("p0_ld", obs, S_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step(); check("p0_full_wins", obs, S_FFS);
        fifo_full = 1'b0;
        step(); check("p0_laf", obs, S_LAF);
        parity_done = 1'b1; low_pkt_valid = 1'b1;
        step(); check("p0_pdone_wins", obs, S_DEC);
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        step(); check("p0_idle", obs, S_DEC);

        // Soft reset: only the selected FIFO's timeout aborts the wait.
        fifo_empty_0 = 1'b0; pkt_valid = 1'b1; data_in = 2'd0;
        step(); check("sr_wte", obs, S_WTE);
        pkt_valid = 1'b0; soft_reset_1 = 1'b1;
        step(); check("sr_other_ignored", obs, S_WTE);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step(); check("sr_selected", obs, S_DEC);
        soft_reset_0 = 1'b0;
        step(); check("sr_idle", obs, S_DEC);

        // Header addressed to port 3.
        pkt_valid = 1'b1; data_in = 2'd3;
`ifdef ROUTER_FSM_ADDR_CHK_EN
        for (int i = 0; i < 3; i++) begin
            step(); check($sformatf("a3_drop%0d", i), obs, S_DROP);
        end
`else
        for (int i = 0; i < 3; i++) begin
            step(); check($sformatf("a3_stay%0d", i), obs, S_DEC);
        end
`endif
        pkt_valid = 1'b0;
        step(); check("a3_back", obs, S_DEC);

        // Asynchronous reset mid-payload.
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        step(); check("ar_lfd", obs, S_LFD);
        step(); check("ar_ld", obs, S_LD);
        #2 rst = 1'b1;
        #1 check("ar_immediate", obs, S_DEC);
        pkt_valid = 1'b0;
        step(); check("ar_held", obs, S_DEC);
        rst = 1'b0;
        step(); check("ar_released", obs, S_DEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
